mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for a shared 4:1 data mux. Four requesters

---
 rtl/mux_arb_pkg.sv | 30 +++
 rtl/rr_pick4.sv | 40 ++++
 rtl/mux4_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module   : mux_arb_pkg
// Desc     : Shared constants, FSM state type and index helper for the
//            4-way round-robin mux arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module   : rr_pick4
// Desc     : Combinational round-robin picker; searches ptr+1, ptr+2, ptr+3,
//            ptr over the unmasked requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl_mask,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_first;
  logic [SEL_W-1:0]   w_pos;

  always_comb begin
    w_cand = req & ~excl_mask;
    w_rot  = '0;
    w_pos  = '0;
    // Rotate so that bit 0 is the highest-priority candidate (ptr+1).
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos    = ptr + SEL_W'(k + 1);
      w_rot[k] = w_cand[w_pos];
    end
    w_first = w_rot & (~w_rot + NUM_REQ'(1));
    idx     = ptr + SEL_W'(1) + onehot_to_idx(w_first);
    any     = |w_cand;
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter
// Desc     : Round-robin arbiter with tenure cap driving a registered 4:1 mux.
// Config   : define MUX_ARB_LOCK_EN to add the lock port (suppresses preemption).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int MAX_TENURE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_vld
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic               lock
`endif
);

  localparam int                c_ten_w   = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [c_ten_w-1:0] c_ten_max = c_ten_w'(MAX_TENURE - 1);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_ten_w-1:0] r_ten, w_ten_nxt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_vld;

  logic [SEL_W-1:0]   w_win;
  logic               w_any;
  logic               w_lock;
  logic               w_release;
  logic               w_preempt;
  logic               w_take;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // The current grantee is masked so both release and preempt look only at others.
  rr_pick4 u_pick (
    .req       (req),
    .ptr       (r_ptr),
    .excl_mask (r_gnt),
    .idx       (w_win),
    .any       (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_ten_nxt   = r_ten;
    w_take      = 1'b0;
    w_release   = ~req[r_sel];
    w_preempt   = (r_ten == c_ten_max) && req[r_sel] && w_any && !w_lock;

    case (r_state)
      IDLE: begin
        if (w_any) w_take = 1'b1;
      end
      GRANT: begin
        if (w_release) begin
          if (w_any) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (w_preempt) begin
          w_take = 1'b1;
        end else if (r_ten != c_ten_max) begin
          w_ten_nxt = r_ten + c_ten_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = GRANT;
      w_gnt_nxt   = NUM_REQ'(1) << w_win;
      w_sel_nxt   = w_win;
      w_ptr_nxt   = w_win;
      w_ten_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(NUM_REQ - 1);
      r_ten   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ten   <= w_ten_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      case (r_sel)
        2'd0:    r_dout <= d0;
        2'd1:    r_dout <= d1;
        2'd2:    r_dout <= d2;
        default: r_dout <= d3;
      endcase
      r_dout_vld <= |r_gnt;
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Desc     : Scoreboard bench for mux4_rr_arbiter with an owner/held-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int W  = 4;
  localparam int MT = 4;

  typedef struct packed {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] dout;
    logic         vld;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] dout;
  logic         dout_vld;
`ifdef MUX_ARB_LOCK_EN
  logic         lock = 1'b0;
`endif

  mux4_rr_arbiter #(.WIDTH(W), .MAX_TENURE(MT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld)
`ifdef MUX_ARB_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Reference model: who owns the path, last winner, cycles owned so far.
  int         m_owner = -1;
  int         m_ptr   = 3;
  int         m_held  = 0;
  logic [1:0] m_sel   = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input int ex);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (i != ex && r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] dsel(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_held  = 0;
    m_sel   = 2'd0;
  endtask

  // Called at a rising edge with the inputs that were stable before it.
  task automatic model_edge();
    exp_t e;
    int   w;
    e.dout = dsel(int'(m_sel));
    e.vld  = (m_owner >= 0);
    if (m_owner < 0) begin
      w = pick(req, m_ptr, -1);
    end else if (!req[m_owner]) begin
      w = pick(req, m_ptr, m_owner);
      if (w < 0) m_owner = -1;
    end else if (m_held >= MT) begin
      w = pick(req, m_ptr, m_owner);
      if (w < 0) m_held++;
    end else begin
      w = -1;
      m_held++;
    end
    if (w >= 0) begin
      m_owner = w;
      m_ptr   = w;
      m_sel   = 2'(w);
      m_held  = 1;
    end
    e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel = m_sel;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    @(posedge clk);
    model_edge();
    #1;
    req = r;
    d0  = W'($urandom);
    d1  = W'($urandom);
    d2  = W'($urandom);
    d3  = W'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 32'd0);
    chk({tag, "_sel"},  32'(sel), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_vld"},  32'(dout_vld), 32'd0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt",  32'(gnt), 32'(e.gnt));
      chk("sel",  32'(sel), 32'(e.sel));
      chk("dout", 32'(dout), 32'(e.dout));
      chk("vld",  32'(dout_vld), 32'(e.vld));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;
    model_reset();

    // Single requester 0, then idle.
    repeat (4) step(4'b0001);
    repeat (3) step(4'b0000);

    // All requesting: rotation with capped tenure.
    repeat (24) step(4'b1111);
    repeat (2) step(4'b0000);

    // Sole requester never preempted, then release.
    repeat (20) step(4'b0100);
    repeat (3) step(4'b0000);

    // Release handoff from 1 to 3 with no idle cycle.
    repeat (3) step(4'b0010);
    step(4'b1010);
    repeat (4) step(4'b1000);
    repeat (2) step(4'b0000);

    // Async reset mid-grant, then restart from requester 0.
    repeat (6) step(4'b1111);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (8) step(4'b1111);

    // Random phase: patterns held for random lengths.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) step(r);
    end
    repeat (3) step(4'b0000);

    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
